multi_channel_log_arbiter: RTL

Collects samples from NUM_CH ultrasonic receiver channel FIFOs and serialises them onto the single microcontroller output link as tagged bursts. Each channel with data gets a burst in round-robin order. In tagged mode a header word identifying the channel precedes each burst. Sits between the per-channel receiver FIFOs and the uController SPI sender, replacing the single-channel direct hookup.

---
 rtl/multi_channel_log_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/multi_channel_log_arbiter.sv
// Multi-channel log arbiter: round-robin grants over receiver FIFOs, with an
// optional channel header word before each burst on the single output link.
module multi_channel_log_arbiter #(
    parameter int         NUM_CH    = 4,
    parameter int         DATA_W    = 16,
    parameter int         BURST_LEN = 8,
    parameter bit         TAG_EN    = 1'b1,
    parameter logic [7:0] HDR_MARK  = 8'hA5
) (
    input  logic                     SYS_CLK,
    input  logic                     RSTn,
    input  logic                     ON,
    input  logic [NUM_CH-1:0]        CH_EN,
    input  logic [NUM_CH-1:0]        CH_EMPTY,
    input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
    output logic [NUM_CH-1:0]        CH_READ_REQ,
    output logic [DATA_W-1:0]        OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [7:0]               CUR_CH,
    output logic                     BUSY,
    output logic [15:0]              FRAME_CNT
);

    typedef enum logic [1:0] {ARB, HDR, DATA} state_t;

    localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

    state_t              state, stateNext;
    logic [7:0]          rrPtr, curCh, wordCnt;
    logic [15:0]         frameCnt;
    logic [NUM_CH-1:0]   req;
    logic                anyReq, hiFound, grantFire;
    logic [7:0]          loIdx, hiIdx, grantIdx;
    logic                selEmpty;
    logic [DATA_W-1:0]   selData, hdrWord;
    logic                pop, burstEnd;

    assign req       = CH_EN & ~CH_EMPTY;
    assign grantFire = (state == ARB) && ON && anyReq;

    // Round-robin pick: lowest requester above the pointer, else lowest overall (wrap).
    always_comb begin
        anyReq  = 1'b0;
        hiFound = 1'b0;
        loIdx   = '0;
        hiIdx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                anyReq = 1'b1;
                loIdx  = 8'(i);
                if (8'(i) > rrPtr) begin
                    hiFound = 1'b1;
                    hiIdx   = 8'(i);
                end
            end
        end
        grantIdx = hiFound ? hiIdx : loIdx;
    end

    // Head word and empty flag of the granted channel.
    always_comb begin
        selEmpty = 1'b1;
        selData  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (curCh == 8'(i)) begin
                selEmpty = CH_EMPTY[i];
                selData  = CH_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Header word: marker in the top byte, channel number in the low byte.
    always_comb begin
        hdrWord                 = '0;
        hdrWord[DATA_W-1 -: 8]  = HDR_MARK;
        hdrWord[7:0]            = curCh;
    end

    // Next-state and output decode; a burst closes on the last counted word or an empty FIFO.
    always_comb begin
        stateNext = state;
        OUT_VALID = 1'b0;
        OUT_DATA  = '0;
        pop       = 1'b0;
        burstEnd  = 1'b0;
        case (state)
            ARB: begin
                if (ON && anyReq) stateNext = TAG_EN ? HDR : DATA;
            end
            HDR: begin
                OUT_VALID = 1'b1;
                OUT_DATA  = hdrWord;
                if (OUT_READY) stateNext = DATA;
            end
            DATA: begin
                OUT_VALID = ~selEmpty;
                OUT_DATA  = selData;
                pop       = ~selEmpty & OUT_READY;
                if (selEmpty || (pop && wordCnt == LAST_CNT)) begin
                    burstEnd  = 1'b1;
                    stateNext = ARB;
                end
            end
            default: stateNext = ARB;
        endcase
    end

    // State, grant registers, per-burst word count and completed-burst counter.
    always_ff @(posedge SYS_CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ARB;
            curCh    <= '0;
            rrPtr    <= 8'(NUM_CH - 1);
            wordCnt  <= '0;
            frameCnt <= '0;
        end else begin
            state <= stateNext;
            if (grantFire) begin
                curCh   <= grantIdx;
                rrPtr   <= grantIdx;
                wordCnt <= '0;
            end else if (pop) begin
                wordCnt <= wordCnt + 8'd1;
            end
            if (burstEnd) frameCnt <= frameCnt + 16'd1;
        end
    end

    // Pop strobe goes only to the granted channel, in the handshake cycle.
    for (genvar g = 0; g < NUM_CH; g++) begin : gPop
        assign CH_READ_REQ[g] = pop && (curCh == 8'(g));
    end

    assign CUR_CH    = curCh;
    assign BUSY      = (state != ARB);
    assign FRAME_CNT = frameCnt;

endmodule
